// File: rtl/rformat_pkg.sv
// Shared constants and types for the R-format execution sequencer.
package rformat_pkg;

  localparam logic [5:0] FUNCT_ADD    = 6'h20;
  localparam logic [5:0] FUNCT_SUB    = 6'h22;
  localparam logic [5:0] FUNCT_AND    = 6'h24;
  localparam logic [5:0] FUNCT_OR     = 6'h25;
  localparam logic [5:0] FUNCT_SLT    = 6'h2A;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  // Instruction field positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RS_REQ = 3'd1,
    ST_RT_REQ = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/rformat_exec_if.sv
// Instruction handshake, register file port and retire status of the
// R-format sequencer. slave = sequencer side, master = fetch/regfile side.
interface rformat_exec_if #(parameter int DATA_W = 32);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [4:0]        rf_addr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              err;
  logic              ovf;

  modport slave (
    input  instr_valid, instr, rf_rdata,
    output instr_ready, rf_addr, rf_we, rf_wdata, done, result, err, ovf
  );

  modport master (
    output instr_valid, instr, rf_rdata,
    input  instr_ready, rf_addr, rf_we, rf_wdata, done, result, err, ovf
  );
endinterface

// File: rtl/rformat_alu.sv
// Combinational ALU for the supported R-format functs.
// Signed ADD/SUB overflow detection exists only when RFORMAT_EXEC_OVF_EN
// is defined; otherwise ovf_o is constant 0.
module rformat_alu
  import rformat_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

`ifdef RFORMAT_EXEC_OVF_EN
  // Same-sign operands producing an opposite-sign sum (ADD), or
  // different-sign operands whose difference flips sign from A (SUB).
  assign add_ovf = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1]  != a_i[DATA_W-1]);
  assign sub_ovf = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
`else
  assign add_ovf = 1'b0;
  assign sub_ovf = 1'b0;
`endif

  // Funct decode; unknown functs report err with a zero result.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    ovf_o    = 1'b0;
    case (funct_i)
      FUNCT_ADD: begin
        result_o = sum;
        ovf_o    = add_ovf;
      end
      FUNCT_SUB: begin
        result_o = diff;
        ovf_o    = sub_ovf;
      end
      FUNCT_AND: result_o = a_i & b_i;
      FUNCT_OR:  result_o = a_i | b_i;
      FUNCT_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:   err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/rformat_exec.sv
// R-format instruction sequencer: accepts one instruction, reads rs and rt
// through the single-port register file, executes, and writes rd back.
// Optional macro RFORMAT_EXEC_OVF_EN enables signed overflow detection
// (overflowing ADD/SUB is reported on ovf and not written back).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new instruction
// RS_REQ    | register file address = rs
// RT_REQ    | address = rt; rs data returns and is captured as operand A
// EXEC      | rt data returns; ALU result, err and ovf are registered
// WB        | one-cycle write of the result to rd
// DONE      | one-cycle retire pulse
module rformat_exec
  import rformat_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit CHECK_OPCODE = 1'b1
) (
  input logic          clock,
  input logic          reset,
  rformat_exec_if.slave bus
);

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_err;
  logic              alu_ovf;
  logic              opcode_bad;
  logic [DATA_W-1:0] exec_result;
  logic              exec_err;
  logic              exec_ovf;
  logic [4:0]        rs, rt, rd;

  logic              ready_c;
  logic [4:0]        addr_c;
  logic              we_c;
  logic              done_c;

  // shamt is not used by any supported instruction
  logic              unused_shamt;
  assign unused_shamt = ^instr_q[10:6];

  assign rs = instr_q[RS_MSB:RS_LSB];
  assign rt = instr_q[RT_MSB:RT_LSB];
  assign rd = instr_q[RD_MSB:RD_LSB];

  // Operand B is taken straight from the read port in EXEC.
  rformat_alu #(.DATA_W(DATA_W)) u_alu (
    .funct_i  (instr_q[FUNCT_MSB:FUNCT_LSB]),
    .a_i      (opa_q),
    .b_i      (bus.rf_rdata),
    .result_o (alu_result),
    .err_o    (alu_err),
    .ovf_o    (alu_ovf)
  );

  // A bad opcode overrides whatever the funct decode produced.
  assign opcode_bad  = CHECK_OPCODE && (instr_q[OP_MSB:OP_LSB] != OPCODE_RTYPE);
  assign exec_err    = alu_err | opcode_bad;
  assign exec_result = opcode_bad ? '0 : alu_result;
  assign exec_ovf    = alu_ovf & ~opcode_bad;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      opa_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, datapath updates and register-file port control.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    ready_c  = 1'b0;
    addr_c   = 5'd0;
    we_c     = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RS_REQ;
        end
      end
      ST_RS_REQ: begin
        addr_c  = rs;
        state_d = ST_RT_REQ;
      end
      ST_RT_REQ: begin
        addr_c  = rt;
        opa_d   = bus.rf_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = exec_result;
        err_d    = exec_err;
        ovf_d    = exec_ovf;
        // $0 is never written; errors and overflows skip writeback too.
        if (exec_err || exec_ovf || (rd == 5'd0)) state_d = ST_DONE;
        else                                      state_d = ST_WB;
      end
      ST_WB: begin
        addr_c  = rd;
        we_c    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so a write pending in the
  // current state can never reach the register file.
  assign bus.instr_ready = reset & ready_c;
  assign bus.rf_addr     = reset ? addr_c : 5'd0;
  assign bus.rf_we       = reset & we_c;
  assign bus.rf_wdata    = (reset && we_c) ? result_q : '0;
  assign bus.done        = reset & done_c;
  assign bus.result      = reset ? result_q : '0;
  assign bus.err         = reset & err_q;
  assign bus.ovf         = reset & ovf_q;

endmodule

// File: tb/tb_rformat_exec.sv
// Directed bench for rformat_exec with a behavioural single-port regfile.
module tb_rformat_exec;

  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  rformat_exec_if #(.DATA_W(DATA_W)) bus ();

  rformat_exec #(.DATA_W(DATA_W), .CHECK_OPCODE(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register file model: one access per cycle, registered read.
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] rdata_m = '0;
  assign bus.rf_rdata = rdata_m;

  int cyc_cnt = 0;
  int wr_cnt  = 0;
  logic [4:0]        wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  int acc_q[$];
  int done_q[$];

  always @(posedge clock) begin
    cyc_cnt = cyc_cnt + 1;
    if (bus.rf_we) begin
      rf[bus.rf_addr] = bus.rf_wdata;
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.rf_addr;
      wr_data = bus.rf_wdata;
    end else begin
      rdata_m <= rf[bus.rf_addr];
    end
    if (bus.instr_valid && bus.instr_ready) acc_q.push_back(cyc_cnt);
    if (bus.done) done_q.push_back(cyc_cnt);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp_result;
    logic        exp_err;
    logic        exp_ovf;
    logic        exp_wr;
    logic [4:0]  exp_waddr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  // Offer one instruction, return cycles from accept to done (99 on timeout).
  task automatic run_instr(input logic [31:0] ins, output int lat);
    for (int k = 0; k < 20 && !bus.instr_ready; k++) @(negedge clock);
    check("ready_before_offer", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int w0;
    int na, nd;

    vecs[0]  = '{32'h0022_1820, 32'd212, 32'd32, 32'd244,        1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[1]  = '{32'h0022_1822, 32'd212, 32'd32, 32'd180,        1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[2]  = '{32'h0022_1824, 32'd212, 32'd32, 32'd0,          1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[3]  = '{32'h0022_1825, 32'd212, 32'd32, 32'd244,        1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[4]  = '{32'h0041_182A, 32'd212, 32'd32, 32'd1,          1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[5]  = '{32'h0022_183F, 32'd212, 32'd32, 32'd0,          1'b1, 1'b0, 1'b0, 5'd3, 4};
    vecs[6]  = '{32'h2022_1820, 32'd212, 32'd32, 32'd0,          1'b1, 1'b0, 1'b0, 5'd3, 4};
    vecs[7]  = '{32'h0022_0020, 32'd212, 32'd32, 32'd244,        1'b0, 1'b0, 1'b0, 5'd0, 4};
`ifdef RFORMAT_EXEC_OVF_EN
    vecs[8]  = '{32'h0022_1820, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd3, 4};
`else
    vecs[8]  = '{32'h0022_1820, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 5'd3, 5};
`endif
    vecs[9]  = '{32'h0022_182A, 32'hFFFF_FFFB, 32'd3, 32'd1,        1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[10] = '{32'h0022_1822, 32'd0,       32'd1,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd3, 5};
    vecs[11] = '{32'h0021_0820, 32'd212,     32'd32, 32'd424,       1'b0, 1'b0, 1'b1, 5'd1, 5};

    for (int i = 0; i < 32; i++) rf[i] = '0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready",  {31'd0, bus.instr_ready}, 32'd0);
    check("rst_we",     {31'd0, bus.rf_we},       32'd0);
    check("rst_addr",   {27'd0, bus.rf_addr},     32'd0);
    check("rst_wdata",  bus.rf_wdata,             32'd0);
    check("rst_done",   {31'd0, bus.done},        32'd0);
    check("rst_result", bus.result,               32'd0);
    check("rst_err",    {31'd0, bus.err},         32'd0);
    check("rst_ovf",    {31'd0, bus.ovf},         32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_ready", {31'd0, bus.instr_ready}, 32'd1);

    // Table-driven instructions
    for (int i = 0; i < 12; i++) begin
      rf[1] = vecs[i].r1;
      rf[2] = vecs[i].r2;
      rf[3] = 32'hDEAD_BEEF;
      w0 = wr_cnt;
      run_instr(vecs[i].instr, lat);
      check($sformatf("v%0d_lat", i),    lat,                    vecs[i].exp_lat);
      check($sformatf("v%0d_result", i), bus.result,             vecs[i].exp_result);
      check($sformatf("v%0d_err", i),    {31'd0, bus.err},       {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_ovf", i),    {31'd0, bus.ovf},       {31'd0, vecs[i].exp_ovf});
      check($sformatf("v%0d_wrcnt", i),  wr_cnt - w0,            {31'd0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) begin
        check($sformatf("v%0d_waddr", i), {27'd0, wr_addr},      {27'd0, vecs[i].exp_waddr});
        check($sformatf("v%0d_wdata", i), wr_data,               vecs[i].exp_result);
        check($sformatf("v%0d_rf", i),    rf[vecs[i].exp_waddr], vecs[i].exp_result);
      end else begin
        check($sformatf("v%0d_rf3_kept", i), rf[3], 32'hDEAD_BEEF);
      end
      @(negedge clock);
      check($sformatf("v%0d_done_1cyc", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("v%0d_err_held", i),  {31'd0, bus.err},  {31'd0, vecs[i].exp_err});
    end

    // Reset asserted during RT_REQ aborts with no write
    rf[1] = 32'd212;
    rf[2] = 32'd32;
    w0 = wr_cnt;
    nd = done_q.size();
    for (int k = 0; k < 20 && !bus.instr_ready; k++) @(negedge clock);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0022_1820;
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clock);            // RS_REQ
    @(negedge clock);            // RT_REQ
    check("mid_rt_addr", {27'd0, bus.rf_addr}, 32'd2);
    reset = 1'b0;
    @(negedge clock);
    check("mid_ready",  {31'd0, bus.instr_ready}, 32'd0);
    check("mid_we",     {31'd0, bus.rf_we},       32'd0);
    check("mid_addr",   {27'd0, bus.rf_addr},     32'd0);
    check("mid_result", bus.result,               32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_back_idle", {31'd0, bus.instr_ready}, 32'd1);
    repeat (8) @(negedge clock);
    check("mid_no_write", wr_cnt - w0,             32'd0);
    check("mid_no_done",  done_q.size() - nd,      32'd0);
    check("mid_result2",  bus.result,              32'd0);

    // Back-to-back: instr_valid held high across two instructions
    rf[1] = 32'd212;
    rf[2] = 32'd32;
    w0 = wr_cnt;
    na = acc_q.size();
    nd = done_q.size();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0022_1820;
    for (int k = 0; k < 30 && acc_q.size() < na + 2; k++) @(negedge clock);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 20 && done_q.size() < nd + 2; k++) @(negedge clock);
    check("b2b_accepts", acc_q.size() - na,  32'd2);
    check("b2b_dones",   done_q.size() - nd, 32'd2);
    if (acc_q.size() >= na + 2 && done_q.size() >= nd + 2) begin
      check("b2b_spacing",   acc_q[na+1] - acc_q[na],  32'd6);
      check("b2b_done_lat",  done_q[nd] - acc_q[na],   32'd5);
      check("b2b_after_done", {31'd0, (acc_q[na+1] > done_q[nd])}, 32'd1);
    end
    check("b2b_writes", wr_cnt - w0, 32'd2);
    check("b2b_rf3",    rf[3],       32'd244);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rformat_exec.md
Name: rformat_exec

Overview:
- Sequencer for single-cycle-issue MIPS R-format instructions.
- Accepts one 32-bit instruction through a valid/ready handshake and decodes rs/rt/rd/funct.
- Reads rs and rt through the single-port register file interface (one access per cycle, 1-cycle registered read latency), computes the ALU result, and writes it back to rd.
- Sits between instruction fetch and the register file; owns the register file port while busy.

Parameters:
- DATA_W, 32, register/ALU data width.
- CHECK_OPCODE, 1, if 1 then instr[31:26] != 0 is flagged as an error; if 0 the opcode is ignored.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block idle and able to accept.
- instr  in  32  R-format instruction word.
- rf_addr  out  5  register file address.
- rf_we  out  1  register file write enable.
- rf_wdata  out  DATA_W  register file write data.
- rf_rdata  in  DATA_W  register file read data; valid the cycle after the address is presented with rf_we=0.
- done  out  1  one-cycle pulse when the instruction retires.
- result  out  DATA_W  ALU result of the last retired instruction.
- err  out  1  last instruction was unsupported; valid with done, held until next accept.
- ovf  out  1  signed overflow (only with the macro; tied 0 otherwise).

Behaviour:
- Reset: clock is clock; reset is synchronous, active-low.
  - While reset=0: state IDLE; instr_ready=0, rf_we=0, rf_addr=0, rf_wdata=0, done=0, result=0, err=0, ovf=0.
  - Reset asserted mid-instruction: abort, return to IDLE, no write is ever issued. rf_we is 0 in the cycle following the reset edge.
- States: IDLE -> RS_REQ -> RT_REQ -> EXEC -> WB -> DONE -> IDLE.
- IDLE:
  - instr_ready=1 (when reset=1).
  - On instr_valid & instr_ready, latch instr and go to RS_REQ.
- RS_REQ: rf_addr=rs, rf_we=0.
- RT_REQ: rf_addr=rt, rf_we=0; capture rf_rdata into opA at the end of the cycle.
- EXEC:
  - Capture rf_rdata into opB.
  - Compute and register result; evaluate err/ovf.
- ALU, selected by funct:
  - 0x20 ADD: A+B, mod 2^DATA_W.
  - 0x22 SUB: A-B, mod 2^DATA_W.
  - 0x24 AND: A&B.
  - 0x25 OR: A|B.
  - 0x2A SLT: signed A<B gives 1, else 0.
  - Any other funct (or nonzero opcode with CHECK_OPCODE=1): err=1, result=0.
- After EXEC:
  - To WB unless err=1, rd==0, or ovf=1; in those cases go directly to DONE.
  - rd==0 is not an error: result is still computed and reported, but $0 is never written.
- WB: rf_addr=rd, rf_we=1, rf_wdata=result, for exactly one cycle.
- DONE:
  - done=1 for one cycle.
  - result/err/ovf hold their values until the next accept.
  - Next state IDLE.
- Latency:
  - done asserts 5 cycles after the accepting edge (4 when WB is skipped).
  - Throughput: one instruction per 6 cycles.
- Handshake:
  - instr is sampled only on the accepting edge; later changes to instr are ignored.
  - instr_valid while busy is not accepted and is left pending.
- rs==rt is legal; both reads are still issued.
- rd equal to rs or rt is legal; operands are captured before WB.

Optional Feature:
- Macro RFORMAT_EXEC_OVF_EN.
- Defined:
  - ADD/SUB signed overflow sets ovf=1 and suppresses WB.
  - result still shows the wrapped value.
- Undefined: no overflow logic; ovf tied 0; wrapped result is written normally.

Decomposition:
- Package rformat_pkg contains:
  - FUNCT_ADD/SUB/AND/OR/SLT constants.
  - OPCODE_RTYPE=6'h00.
  - State enum type.
  - Field position constants (rs 25:21, rt 20:16, rd 15:11, funct 5:0).
- One sub-module, rformat_alu: purely combinational; inputs funct, A, B; outputs result, err, ovf.
- FSM and handshake live in rformat_exec.

Test Plan:
- Preload $1=212, $2=32 via a regfile model. Offer ADD 0x00221820 -> accepted in IDLE; rf_we pulse with rf_addr=3, rf_wdata=244; done 5 cycles after accept; err=0.
- SUB 0x00221822 -> $3=180. AND 0x00221824 -> $3=0. OR 0x00221825 -> $3=244. SLT rs=2, rt=1 -> $3=1.
- funct 0x3F, or opcode 0x08 with CHECK_OPCODE=1 -> err=1 with done after 4 cycles; no rf_we.
- rd=0 ADD (0x00220020) -> result=244, done asserted, rf_we never high.
- $1=0x7FFFFFFF, $2=1, ADD:
  - With RFORMAT_EXEC_OVF_EN: ovf=1, no write, result=0x80000000.
  - Without the macro: $3 written with 0x80000000.
- Reset driven low during RT_REQ -> next cycle IDLE, all outputs 0, no write. Back-to-back instr_valid held high -> second instruction accepted only after DONE.
